// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: register/data-memory widths plus the load/store unit's size and state encodings.
package mips_cpu_pkg;

    localparam int XLEN  = 32;
    localparam int DM_AW = 10;

    typedef logic [XLEN-1:0]  reg_t;
    typedef logic [DM_AW-1:0] dm_addr_t;

    localparam reg_t ZERO = '0;

    // Encoding 3 is not named; it behaves as WORD everywhere.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        LD_RSP,
        RMW_WR,
        ST_RSP
    } lsu_state_t;

    function automatic logic is_word(input mem_size_t size);
        return size[1];
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extracts a zero/sign-extended load value from a memory word and
// merges right-justified store data into the addressed byte/half lane of a memory word.
module lsu_byte_lane
    import mips_cpu_pkg::*;
(
    input  mem_size_t  size_i,
    input  logic       sext_i,
    input  logic [1:0] lane_i,
    input  reg_t       rword_i,
    input  reg_t       wdata_i,
    output reg_t       ld_data_o,
    output reg_t       st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        ld_data_o = rword_i;
        st_word_o = wdata_i;
        if (!is_word(size_i)) begin
            st_word_o = rword_i;
            if (size_i == HALF) begin
                ld_data_o = {{16{sext_i & half_sel[15]}}, half_sel};
                st_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end else begin
                ld_data_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
                st_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-write, 1-cycle sync-read data memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_EXC_EN to flag misaligned HALF/WORD accesses instead of aligning down.
module mem_lsu
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  mem_size_t         req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  reg_t              req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output reg_t              rsp_rdata,
    output logic              misalign,
    output logic              dmce,
    output logic              dmwe,
    output dm_addr_t          dmaddr,
    output reg_t              dmdin,
    input  reg_t              dmdout
);

    lsu_state_t       state_q, state_d;
    logic [DM_AW+1:0] addr_q;
    mem_size_t        size_q;
    logic             sext_q;
    reg_t             wdata_q;
    logic             idle_w, accept_w, mis_w;
    reg_t             ld_data_w, st_word_w;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[ADDR_W-1:DM_AW+2];

    assign idle_w    = (state_q == IDLE) && !cpu_rst;
    assign req_ready = idle_w;
    assign accept_w  = idle_w && req_valid;

`ifdef LSU_MISALIGN_EXC_EN
    logic mis_q;
    assign mis_w    = ((req_size == HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign misalign = !cpu_rst && (state_q == ST_RSP) && mis_q;
`else
    assign mis_w    = 1'b0;
    assign misalign = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .size_i    (size_q),
        .sext_i    (sext_q),
        .lane_i    (addr_q[1:0]),
        .rword_i   (dmdout),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data_w),
        .st_word_o (st_word_w)
    );

    always_comb begin
        state_d   = state_q;
        dmce      = 1'b0;
        dmwe      = 1'b0;
        dmaddr    = addr_q[DM_AW+1:2];
        dmdin     = ZERO;
        rsp_valid = 1'b0;
        rsp_rdata = ZERO;
        if (cpu_rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    dmaddr = req_addr[DM_AW+1:2];
                    if (req_valid) begin
                        if (mis_w) begin
                            state_d = ST_RSP;
                        end else begin
                            dmce = 1'b1;
                            if (!req_we) begin
                                state_d = LD_RSP;
                            end else if (is_word(req_size)) begin
                                dmwe    = 1'b1;
                                dmdin   = req_wdata;
                                state_d = ST_RSP;
                            end else begin
                                state_d = RMW_WR;
                            end
                        end
                    end
                end
                LD_RSP: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = ld_data_w;
                    state_d   = IDLE;
                end
                RMW_WR: begin
                    dmce    = 1'b1;
                    dmwe    = 1'b1;
                    dmdin   = st_word_w;
                    state_d = ST_RSP;
                end
                ST_RSP: begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            // NOTE: only control state is reset; the capture registers are always written at
            // accept before anything reads them, so they need no reset value.
            state_q <= IDLE;
`ifdef LSU_MISALIGN_EXC_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept_w) begin
                addr_q  <= req_addr[DM_AW+1:0];
                size_q  <= req_size;
                sext_q  <= req_sext;
                wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EXC_EN
                mis_q   <= mis_w;
`endif
            end
        end
    end

endmodule
